// File: rtl/float_operator_arbiter.sv
// float_operator_arbiter
// Shares one pipelined float_operator between N_REQ requesters. A round-robin
// arbiter issues at most one request per cycle. A tag pipeline that matches the
// operator latency routes each returning result back to the requester that
// issued it.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   hold            blocks new issues; ops already in flight still complete
//   req_valid       per-requester request pending
//   req_a, req_b    packed 32-bit operands; requester i uses [32i+31:32i]
//   req_ready       one-hot grant (a transfer happens on valid & ready)
//   resp_valid      one-hot; resp_data holds that requester's result
//   resp_data       shared result word, 0 when no response is present
//   op_valid/op_a/op_b   issue interface to float_operator
//   op_done/op_result    completion interface from float_operator
//   inflight        number of issued ops that have not yet returned
//   idle            no op in flight and no issue this cycle
//   err             sticky: an expected result was missing (lost op_done)
module float_operator_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             hold,
    input  logic [N_REQ-1:0]                 req_valid,
    input  logic [32*N_REQ-1:0]              req_a,
    input  logic [32*N_REQ-1:0]              req_b,
    output logic [N_REQ-1:0]                 req_ready,
    output logic [N_REQ-1:0]                 resp_valid,
    output logic [31:0]                      resp_data,
    output logic                             op_valid,
    output logic [31:0]                      op_a,
    output logic [31:0]                      op_b,
    input  logic                             op_done,
    input  logic [31:0]                      op_result,
    output logic [$clog2(LATENCY+1)-1:0]     inflight,
    output logic                             idle,
    output logic                             err
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(LATENCY+1);

    logic [ID_W-1:0]  r_last_grant;
    logic             r_tag_v  [LATENCY];
    logic [ID_W-1:0]  r_tag_id [LATENCY];
    logic [CNT_W-1:0] r_inflight;
    logic             r_err;

    logic             w_grant_hit;
    logic [ID_W-1:0]  w_grant_id;
    logic [ID_W-1:0]  w_scan_idx;
    logic             w_last_v;
    logic [ID_W-1:0]  w_last_id;
    logic             w_resp_fire;
    logic             w_lost;

    // Round-robin scan starting just after the last grant. Reset also gates
    // the grant so that every issue-side output reads zero while rst is high.
    always_comb begin
        w_grant_hit = 1'b0;
        w_grant_id  = '0;
        w_scan_idx  = '0;
        if (!rst && !hold) begin
            for (int unsigned k = 1; k <= N_REQ; k++) begin
                w_scan_idx = ID_W'((32'(r_last_grant) + k) % N_REQ);
                if (!w_grant_hit && req_valid[w_scan_idx]) begin
                    w_grant_hit = 1'b1;
                    w_grant_id  = w_scan_idx;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        op_a      = '0;
        op_b      = '0;
        if (w_grant_hit) begin
            req_ready = N_REQ'(1) << w_grant_id;
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_grant_hit && (w_grant_id == ID_W'(i))) begin
                op_a = req_a[32*i +: 32];
                op_b = req_b[32*i +: 32];
            end
        end
    end

    assign op_valid = w_grant_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= ID_W'(N_REQ-1);
        end else if (w_grant_hit) begin
            r_last_grant <= w_grant_id;
        end
    end

    // Tag pipeline: it never stalls, so the last stage lines up exactly with
    // op_done for the op issued LATENCY cycles earlier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                r_tag_v[i]  <= 1'b0;
                r_tag_id[i] <= '0;
            end
        end else begin
            r_tag_v[0]  <= op_valid;
            r_tag_id[0] <= w_grant_id;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    assign w_last_v    = r_tag_v[LATENCY-1];
    assign w_last_id   = r_tag_id[LATENCY-1];
    // A done without a valid tag is a stale pulse from before reset: ignore it.
    assign w_resp_fire = w_last_v & op_done;
    assign w_lost      = w_last_v & ~op_done;

    assign resp_valid = w_resp_fire ? (N_REQ'(1) << w_last_id) : '0;
    assign resp_data  = w_resp_fire ? op_result : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({op_valid, w_last_v})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_lost) begin
            r_err <= 1'b1;
        end
    end

    // err is visible in the same cycle as the missing done, then held.
    assign err      = r_err | w_lost;
    assign inflight = r_inflight;
    assign idle     = (r_inflight == '0) & ~op_valid;

endmodule

// File: tb/tb_float_operator_arbiter.sv
// tb_float_operator_arbiter
// Self-checking bench for float_operator_arbiter. A stand-in float operator
// (fixed-latency pipeline, no reset) drives op_done/op_result. A queue-based
// reference model predicts grants, responses, inflight, idle and err.
// A second instance uses LATENCY=1 and N_REQ=2 and is checked with directed
// stimulus.
module tb_float_operator_arbiter;

    localparam int N  = 4;
    localparam int L  = 5;
    localparam int N1 = 2;
    localparam int L1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, hold, kill, emu_clr;
    logic [N-1:0]      req_valid, req_ready, resp_valid;
    logic [32*N-1:0]   req_a, req_b;
    logic [31:0]       resp_data, op_a, op_b, op_result;
    logic              op_valid, op_done, idle, err;
    logic [$clog2(L+1)-1:0] inflight;

    logic [N1-1:0]     d1_valid, d1_ready, d1_resp_valid;
    logic [32*N1-1:0]  d1_a, d1_b;
    logic [31:0]       d1_resp_data, d1_op_a, d1_op_b, d1_op_result;
    logic              d1_op_valid, d1_op_done, d1_idle, d1_err;
    logic [$clog2(L1+1)-1:0] d1_inflight;

    int n_checks = 0;
    int n_fail   = 0;

    float_operator_arbiter #(.N_REQ(N), .LATENCY(L)) u_dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
        .op_done(op_done), .op_result(op_result),
        .inflight(inflight), .idle(idle), .err(err)
    );

    float_operator_arbiter #(.N_REQ(N1), .LATENCY(L1)) u_dut_l1 (
        .clk(clk), .rst(rst), .hold(1'b0),
        .req_valid(d1_valid), .req_a(d1_a), .req_b(d1_b),
        .req_ready(d1_ready), .resp_valid(d1_resp_valid), .resp_data(d1_resp_data),
        .op_valid(d1_op_valid), .op_a(d1_op_a), .op_b(d1_op_b),
        .op_done(d1_op_done), .op_result(d1_op_result),
        .inflight(d1_inflight), .idle(d1_idle), .err(d1_err)
    );

    // Stand-in operator: two known float results, otherwise a hash.
    function automatic logic [31:0] fop(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000; // 1.0 + 2.0
        if (a == 32'h40400000 && b == 32'h40000000) return 32'h40C00000; // 3.0 * 2.0
        return (a ^ {b[12:0], b[31:13]}) + 32'h9E3779B9;
    endfunction

    // Operator pipelines have no reset, so dones issued before rst still drain.
    logic        emu_v [1:L];
    logic [31:0] emu_r [1:L];
    logic        e1_v;
    logic [31:0] e1_r;

    always @(posedge clk) begin
        if (emu_clr) begin
            for (int i = 1; i <= L; i++) begin
                emu_v[i] <= 1'b0;
                emu_r[i] <= '0;
            end
            e1_v <= 1'b0;
            e1_r <= '0;
        end else begin
            emu_v[1] <= op_valid;
            emu_r[1] <= fop(op_a, op_b);
            for (int i = 2; i <= L; i++) begin
                emu_v[i] <= emu_v[i-1];
                emu_r[i] <= emu_r[i-1];
            end
            e1_v <= d1_op_valid;
            e1_r <= fop(d1_op_a, d1_op_b);
        end
    end

    assign op_done      = emu_v[L] & ~kill;
    assign op_result    = emu_r[L];
    assign d1_op_done   = e1_v;
    assign d1_op_result = e1_r;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } pend_t;

    pend_t q[$];
    int    m_last;
    bit    m_err;
    int    cyc;
    bit    rand_ops;

    // One clock cycle: drive at negedge, check settled outputs, advance model.
    task automatic cycle(input logic h, input logic [N-1:0] v, input logic k, input logic r);
        logic [N-1:0] e_ready, e_resp;
        logic [31:0]  e_a, e_b, e_data;
        int           gid;
        @(negedge clk);
        rst = r; hold = h; req_valid = v; kill = k;
        if (rand_ops) begin
            for (int i = 0; i < N; i++) begin
                req_a[32*i +: 32] = $urandom;
                req_b[32*i +: 32] = $urandom;
            end
        end
        #1;
        e_ready = '0; e_resp = '0; e_a = '0; e_b = '0; e_data = '0; gid = -1;
        if (r) begin
            q.delete();
            m_last = N - 1;
            m_err  = 1'b0;
        end else begin
            if (!h) begin
                for (int s = 1; s <= N; s++) begin
                    int c;
                    c = (m_last + s) % N;
                    if (gid < 0 && v[c]) gid = c;
                end
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                if (k) m_err = 1'b1;
                else begin
                    e_resp[q[0].id] = 1'b1;
                    e_data = q[0].data;
                end
            end
        end
        if (gid >= 0) begin
            e_ready[gid] = 1'b1;
            e_a = req_a[32*gid +: 32];
            e_b = req_b[32*gid +: 32];
        end
        check_eq("req_ready", req_ready, e_ready);
        check_eq("op_valid", op_valid, gid >= 0);
        if (gid >= 0 || r) begin
            check_eq("op_a", op_a, e_a);
            check_eq("op_b", op_b, e_b);
        end
        check_eq("resp_valid", resp_valid, e_resp);
        check_eq("resp_data", resp_data, e_data);
        check_eq("inflight", inflight, q.size());
        check_eq("idle", idle, (q.size() == 0) && (gid < 0));
        check_eq("err", err, m_err);
        if (!r && q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
        if (gid >= 0) begin
            q.push_back('{due: cyc + L, id: gid, data: fop(e_a, e_b)});
            m_last = gid;
        end
        cyc++;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; kill = 1'b0; emu_clr = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0;
        d1_valid = '0; d1_a = '0; d1_b = '0;
        rand_ops = 1'b1; m_last = N - 1; m_err = 1'b0; cyc = 0;
        repeat (2) @(negedge clk);
        emu_clr = 1'b0;

        // Reset values on both instances
        cycle(1'b0, '0, 1'b0, 1'b1);
        check_eq("l1_rst_ready", d1_ready, 0);
        check_eq("l1_rst_idle", d1_idle, 1);

        // LATENCY=1: req 0 then req 1, results one cycle after each issue
        @(negedge clk);
        rst = 1'b0;
        d1_valid = 2'b11;
        d1_a = {32'h40400000, 32'h40400000};
        d1_b = {32'h40000000, 32'h40000000};
        #1;
        check_eq("l1_ready_c0", d1_ready, 2'b01);
        check_eq("l1_opvalid_c0", d1_op_valid, 1);
        check_eq("l1_resp_c0", d1_resp_valid, 0);
        @(negedge clk);
        d1_valid = 2'b10;
        #1;
        check_eq("l1_ready_c1", d1_ready, 2'b10);
        check_eq("l1_resp_c1", d1_resp_valid, 2'b01);
        check_eq("l1_data_c1", d1_resp_data, 32'h40C00000);
        @(negedge clk);
        d1_valid = 2'b00;
        #1;
        check_eq("l1_ready_c2", d1_ready, 0);
        check_eq("l1_resp_c2", d1_resp_valid, 2'b10);
        check_eq("l1_data_c2", d1_resp_data, 32'h40C00000);
        @(negedge clk);
        #1;
        check_eq("l1_resp_c3", d1_resp_valid, 0);
        check_eq("l1_idle_c3", d1_idle, 1);
        check_eq("l1_err_c3", d1_err, 0);

        // Single request from req 2: 1.0 + 2.0
        cycle(1'b0, '0, 1'b0, 1'b1);
        rand_ops = 1'b0;
        req_a[95:64] = 32'h3F800000;
        req_b[95:64] = 32'h40000000;
        cycle(1'b0, 4'b0100, 1'b0, 1'b0);
        repeat (6) cycle(1'b0, '0, 1'b0, 1'b0);
        rand_ops = 1'b1;

        // All requesters continuously: rotating grants, inflight saturates
        repeat (8) cycle(1'b0, 4'hF, 1'b0, 1'b0);
        repeat (6) cycle(1'b0, '0, 1'b0, 1'b0);

        // hold in the middle of a back-to-back stream
        repeat (3) cycle(1'b0, 4'hF, 1'b0, 1'b0);
        repeat (2) cycle(1'b1, 4'hF, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 4'hF, 1'b0, 1'b0);
        repeat (6) cycle(1'b0, '0, 1'b0, 1'b0);

        // Lost result: suppress op_done exactly when the tag reaches the end
        cycle(1'b0, 4'b0010, 1'b0, 1'b0);
        repeat (4) cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 4'b0001 & 4'b0000, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Reset mid-operation: stale dones must be ignored
        repeat (3) cycle(1'b0, 4'hF, 1'b0, 1'b0);
        cycle(1'b0, 4'hF, 1'b0, 1'b1);
        repeat (8) cycle(1'b0, '0, 1'b0, 1'b0);

        // Randomized traffic with random hold
        repeat (400) cycle($urandom_range(0, 3) == 0, N'($urandom), 1'b0, 1'b0);
        repeat (6) cycle(1'b0, '0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
